rst_pulse_width_monitor: RTL and testbench
==========================================

# rst_pulse_width_monitor

Synthesizable multi-channel monitor that checks active-low reset pulses against a minimum (and optional maximum) low-time, reports violations, and drives a per-channel cleaned reset stretched to at least MIN_LOW cycles. It sits between the reset sources and the reset distribution logic, and moves the reset-width check from a bench-only property into RTL. Monitored inputs are synchronous to `clk`; the block contains no synchronizers.

## Interface
- NUM_CH, 4, number of monitored reset channels (≥1)
- MIN_LOW, 6, minimum legal low-run length in cycles (≥1)
- MAX_LOW, 0, maximum legal low-run length; 0 disables the max check, otherwise MAX_LOW ≥ MIN_LOW
- CNT_W, 16, width of the violation counter

- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  block reset, synchronous, active-low
- mon_rst_n  in  NUM_CH  monitored active-low resets, sampled each posedge
- clr_i  in  1  clears sticky flags and the error counter
- good_o  out  NUM_CH  1-cycle pulse: legal release (MIN_LOW ≤ L, no long violation)
- viol_short_o  out  NUM_CH  1-cycle pulse: release with L < MIN_LOW
- viol_long_o  out  NUM_CH  1-cycle pulse: run reached MAX_LOW+1 samples
- sticky_err_o  out  NUM_CH  per-channel latched violation
- err_cnt_o  out  CNT_W  total violations, saturating
- stretched_rst_n_o  out  NUM_CH  cleaned reset, low ≥ MIN_LOW cycles

## Operation
- L = number of consecutive posedges at which mon_rst_n[i] is sampled 0. Each channel keeps a previous-sample register (reset value 1) and a run counter that saturates at max(MIN_LOW, MAX_LOW+1).
- Fall: sample 0 with prev 1 sets the run counter to 1. Each further 0 sample increments it (saturating).
- Release: sample 1 with prev 0.
  - L < MIN_LOW → viol_short_o.
  - Else, if no long violation fired in this run → good_o.
  - After a long violation the release produces no pulse.
- Long: when MAX_LOW ≠ 0 and the sample makes L = MAX_LOW+1, viol_long_o pulses once per run.
- Each short or long event sets sticky_err_o[i].
- err_cnt_o adds the popcount of all violation pulses in that cycle and saturates at 2^CNT_W−1.
- clr_i: clear is applied first, then the same cycle's events. Result: err_cnt_o = that cycle's popcount and sticky_err_o = that cycle's events.
- Stretcher (per channel, stretch counter s saturating at MIN_LOW):
  - Sample 0 while stretched high → stretched low, s = 1.
  - Fall (prev 1, sample 0) while stretched low → s restarts at 1.
  - While stretched low and no restart → s increments.
  - Stretched returns high at the edge where s ≥ MIN_LOW and the sample is 1.
- Reset (rst_n = 0 at a posedge):
  - Outputs: all pulses 0, sticky 0, err_cnt_o 0, stretched_rst_n_o all 0.
  - Internal: prev all 1, run counters and s cleared.
  - Any in-progress run is discarded without a pulse.
  - After reset release, stretched_rst_n_o stays low at least MIN_LOW cycles. This is reset-out minimum width.

## Timing
- All outputs registered. A pulse is visible for exactly one cycle, starting after the posedge that sampled the triggering event.
- Release detection latency: 1 edge after the first high sample, with no extra pipeline.
- For L ≥ MIN_LOW, stretched_rst_n_o is low for exactly L cycles, shifted one cycle later than mon_rst_n. For L < MIN_LOW it is low for exactly MIN_LOW cycles.
- Channels are fully independent. Simultaneous events on several channels are all reported and counted in the same cycle.
- Constant-low input with MAX_LOW = 0: no pulse ever, counter saturates, stretched stays low.

## Test plan
- NUM_CH=4, MIN_LOW=6, MAX_LOW=10, CNT_W=16 unless stated.
- ch0 low 6 cycles → good_o[0] single pulse on release; no violation; stretched_rst_n_o[0] low exactly 6 cycles.
- ch1 low 3 cycles → viol_short_o[1] pulse; sticky_err_o[1]=1; err_cnt_o=1; stretched_rst_n_o[1] low exactly 6 cycles.
- ch2 low 15 cycles → viol_long_o[2] once, after the 11th low sample; no good/short pulse at release; err_cnt_o +1.
- ch0 and ch3 short releases on the same edge with clr_i=1 → err_cnt_o=2, sticky_err_o=4'b1001. Next cycle without events, clr_i=1 → 0, 4'b0000.
- CNT_W=2, five short violations → err_cnt_o=3 and holds.
- rst_n low for 1 cycle after ch1 has been low 3 cycles → no pulses, all outputs at reset values. After release with mon high, stretched_rst_n_o stays low 6 cycles, then goes high.

Source files
------------

// File: rtl/rst_pulse_width_monitor.sv
// Per-channel active-low reset width checker with short/long violation pulses and a min-width stretched reset.
// Latency: all outputs registered, one edge after the sample. Backpressure: none, a new sample is taken every cycle.
module rst_pulse_width_monitor #(
    parameter int NUM_CH  = 4,
    parameter int MIN_LOW = 6,
    parameter int MAX_LOW = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] mon_rst_n,
    input  logic              clr_i,
    output logic [NUM_CH-1:0] good_o,
    output logic [NUM_CH-1:0] viol_short_o,
    output logic [NUM_CH-1:0] viol_long_o,
    output logic [NUM_CH-1:0] sticky_err_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [NUM_CH-1:0] stretched_rst_n_o
);
    localparam int RUN_SAT = (MIN_LOW > MAX_LOW + 1) ? MIN_LOW : MAX_LOW + 1;
    localparam int RW      = $clog2(RUN_SAT + 1);
    localparam int SW      = $clog2(MIN_LOW + 1);
    localparam int PW      = $clog2(2 * NUM_CH + 1);
    localparam int AW      = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [AW-1:0] CNT_MAX = {{(AW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] long_seen_q, long_seen_d;
    logic [RW-1:0]     run_q [NUM_CH];
    logic [RW-1:0]     run_d [NUM_CH];
    logic [SW-1:0]     str_cnt_q [NUM_CH];
    logic [SW-1:0]     str_cnt_d [NUM_CH];
    logic [NUM_CH-1:0] str_d, good_d, short_d, long_d, sticky_d;
    logic [PW-1:0]     pop;
    logic [AW-1:0]     sum;
    logic [CNT_W-1:0]  cnt_d;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            run_d[i]       = run_q[i];
            long_seen_d[i] = long_seen_q[i];
            str_cnt_d[i]   = str_cnt_q[i];
            str_d[i]       = stretched_rst_n_o[i];
            good_d[i]      = 1'b0;
            short_d[i]     = 1'b0;
            long_d[i]      = 1'b0;

            // Run length tracking; run_q holds L saturated at RUN_SAT
            if (!mon_rst_n[i]) begin
                if (prev_q[i]) begin
                    run_d[i]       = RW'(1);
                    long_seen_d[i] = 1'b0;
                end else if (run_q[i] != RW'(RUN_SAT)) begin
                    run_d[i] = run_q[i] + 1'b1;
                end
                if (MAX_LOW != 0 && !prev_q[i] && run_q[i] == RW'(MAX_LOW)) begin
                    long_d[i]      = 1'b1;
                    long_seen_d[i] = 1'b1;
                end
            end else if (!prev_q[i]) begin
                if (run_q[i] < RW'(MIN_LOW))
                    short_d[i] = 1'b1;
                else if (!long_seen_q[i])
                    good_d[i] = 1'b1;
            end

            // Stretcher: a fall always restarts the minimum-width window
            if (stretched_rst_n_o[i]) begin
                if (!mon_rst_n[i]) begin
                    str_d[i]     = 1'b0;
                    str_cnt_d[i] = SW'(1);
                end
            end else if (!mon_rst_n[i] && prev_q[i]) begin
                str_cnt_d[i] = SW'(1);
            end else if (mon_rst_n[i] && str_cnt_q[i] >= SW'(MIN_LOW)) begin
                str_d[i] = 1'b1;
            end else if (str_cnt_q[i] != SW'(MIN_LOW)) begin
                str_cnt_d[i] = str_cnt_q[i] + 1'b1;
            end

            pop = pop + PW'(short_d[i]) + PW'(long_d[i]);
        end

        sticky_d = (clr_i ? '0 : sticky_err_o) | short_d | long_d;
        sum      = (clr_i ? '0 : AW'(err_cnt_o)) + AW'(pop);
        cnt_d    = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q            <= '1;
            long_seen_q       <= '0;
            good_o            <= '0;
            viol_short_o      <= '0;
            viol_long_o       <= '0;
            sticky_err_o      <= '0;
            err_cnt_o         <= '0;
            stretched_rst_n_o <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                run_q[i]     <= '0;
                str_cnt_q[i] <= '0;
            end
        end else begin
            prev_q            <= mon_rst_n;
            long_seen_q       <= long_seen_d;
            good_o            <= good_d;
            viol_short_o      <= short_d;
            viol_long_o       <= long_d;
            sticky_err_o      <= sticky_d;
            err_cnt_o         <= cnt_d;
            stretched_rst_n_o <= str_d;
            for (int i = 0; i < NUM_CH; i++) begin
                run_q[i]     <= run_d[i];
                str_cnt_q[i] <= str_cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_rst_pulse_width_monitor.sv
// Randomised plus directed bench; a run-length/last-fall reference model feeds an expectation queue.
module tb_rst_pulse_width_monitor;
    localparam int NCH  = 4;
    localparam int MINL = 6;
    localparam int MAXL = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic [NCH-1:0] mon = '1;

    logic [NCH-1:0] good, shrt, lng, sticky, str;
    logic [15:0]    cnt;
    logic [NCH-1:0] good2, shrt2, lng2, sticky2, str2;
    logic [1:0]     cnt2;

    always #5 clk = ~clk;

    rst_pulse_width_monitor #(.NUM_CH(NCH), .MIN_LOW(MINL), .MAX_LOW(MAXL), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mon_rst_n(mon), .clr_i(clr),
        .good_o(good), .viol_short_o(shrt), .viol_long_o(lng),
        .sticky_err_o(sticky), .err_cnt_o(cnt), .stretched_rst_n_o(str));

    rst_pulse_width_monitor #(.NUM_CH(NCH), .MIN_LOW(MINL), .MAX_LOW(MAXL), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .mon_rst_n(mon), .clr_i(clr),
        .good_o(good2), .viol_short_o(shrt2), .viol_long_o(lng2),
        .sticky_err_o(sticky2), .err_cnt_o(cnt2), .stretched_rst_n_o(str2));

    typedef struct packed {
        logic [NCH-1:0] good;
        logic [NCH-1:0] shrt;
        logic [NCH-1:0] lng;
        logic [NCH-1:0] sticky;
        logic [NCH-1:0] str;
        logic [15:0]    cnt;
        logic [1:0]     cnt2;
    } exp_t;

    exp_t q[$];
    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: true (unbounded) run length and the edge of the last fall
    int             t = 0;
    bit             m_prev [NCH];
    int             m_len  [NCH];
    bit             m_longf[NCH];
    int             m_fall [NCH];
    logic [NCH-1:0] m_sticky;
    int             m_cnt, m_cnt2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input logic [NCH-1:0] m, input bit c);
        exp_t e;
        int pop;
        t++;
        e = '0;
        if (!r) begin
            for (int i = 0; i < NCH; i++) begin
                m_prev[i] = 1'b1;
                m_len[i] = 0;
                m_longf[i] = 1'b0;
                m_fall[i] = t + 1;
            end
            m_sticky = '0;
            m_cnt = 0;
            m_cnt2 = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!m[i]) begin
                    if (m_prev[i]) begin
                        m_len[i] = 1;
                        m_longf[i] = 1'b0;
                        m_fall[i] = t;
                    end else begin
                        m_len[i]++;
                    end
                    if (m_len[i] == MAXL + 1) begin
                        e.lng[i] = 1'b1;
                        m_longf[i] = 1'b1;
                    end
                end else if (!m_prev[i]) begin
                    if (m_len[i] < MINL) e.shrt[i] = 1'b1;
                    else if (!m_longf[i]) e.good[i] = 1'b1;
                end
                m_prev[i] = m[i];
                e.str[i] = m[i] && (t - m_fall[i] >= MINL);
            end
            pop = $countones(e.shrt) + $countones(e.lng);
            if (c) begin
                m_sticky = e.shrt | e.lng;
                m_cnt = 0;
                m_cnt2 = 0;
            end else begin
                m_sticky = m_sticky | e.shrt | e.lng;
            end
            m_cnt  = (m_cnt + pop > 65535) ? 65535 : m_cnt + pop;
            m_cnt2 = (m_cnt2 + pop > 3) ? 3 : m_cnt2 + pop;
        end
        e.sticky = m_sticky;
        e.cnt = 16'(m_cnt);
        e.cnt2 = 2'(m_cnt2);
        q.push_back(e);
    endtask

    task automatic drive(input bit r, input logic [NCH-1:0] m, input bit c);
        @(posedge clk);
        #2;
        rst_n = r;
        mon = m;
        clr = c;
        model_step(r, m, c);
    endtask

    task automatic hold(input logic [NCH-1:0] m, input int n);
        for (int k = 0; k < n; k++) drive(1'b1, m, 1'b0);
    endtask

    // Monitor: outputs are presented every cycle, so one expectation is consumed per edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                chk("good", 32'(good), 32'(e.good));
                chk("viol_short", 32'(shrt), 32'(e.shrt));
                chk("viol_long", 32'(lng), 32'(e.lng));
                chk("sticky", 32'(sticky), 32'(e.sticky));
                chk("err_cnt", 32'(cnt), 32'(e.cnt));
                chk("stretched", 32'(str), 32'(e.str));
                chk("w2_err_cnt", 32'(cnt2), 32'(e.cnt2));
                chk("w2_outputs", {12'd0, good2, shrt2, lng2, sticky2, str2},
                    {12'd0, e.good, e.shrt, e.lng, e.sticky, e.str});
            end
        end
    end

    initial begin
        logic [NCH-1:0] rm;
        bit rr, rc;
        repeat (3) drive(1'b0, '1, 1'b0);
        hold(4'b1111, 8);
        hold(4'b1110, 6);
        hold(4'b1111, 8);
        hold(4'b1101, 3);
        hold(4'b1111, 8);
        hold(4'b1011, 15);
        hold(4'b1111, 8);
        hold(4'b0110, 3);
        drive(1'b1, 4'b1111, 1'b1);
        drive(1'b1, 4'b1111, 1'b1);
        hold(4'b1111, 6);
        for (int k = 0; k < 5; k++) begin
            hold(4'b1101, 2);
            hold(4'b1111, 3);
        end
        hold(4'b1111, 6);
        hold(4'b1101, 3);
        drive(1'b0, 4'b1101, 1'b0);
        hold(4'b1111, 10);

        rm = '1;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 5) == 0) rm[i] = ~rm[i];
            rc = ($urandom_range(0, 24) == 0);
            rr = !($urandom_range(0, 399) == 0);
            drive(rr, rm, rc);
        end
        hold(4'b1111, 2);

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
